// File: rtl/debounce_oneshot.sv
// Pushbutton debouncer with one-shot step pulse and press counter.
// Samples the synchronised button on rising edges of a slow strobe and fires once per stable press.
module debounce_oneshot #(
    parameter int unsigned SAMPLES = 10
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       btn_in,
    output logic       db_level,
    output logic       step_pulse,
    output logic [7:0] press_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FIRE = 2'd1;
    localparam logic [1:0] HELD = 2'd2;

    logic [1:0]         slow_sync_q;
    logic [1:0]         btn_sync_q;
    logic [1:0]         sync_vld_q;
    logic               slow_prev_q;
    logic               armed_q, armed_d;
    logic               tick;
    logic [SAMPLES-1:0] shift_q, shift_d;
    logic [1:0]         state_q, state_d;
    logic [7:0]         count_q, count_d;

    // Ticks are only armed once a genuine low level has been seen after reset,
    // so a strobe already high at release cannot fake a rising edge.
    always_comb begin
        armed_d = armed_q | (sync_vld_q[1] & ~slow_sync_q[1]);
        tick    = armed_q & slow_sync_q[1] & ~slow_prev_q;
        shift_d = shift_q;
        if (tick) begin
            shift_d = {shift_q[SAMPLES-2:0], btn_sync_q[1]};
        end
    end

    // Decisions use the post-shift value so the pulse lands one cycle after the tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (&shift_d) state_d = FIRE;
            FIRE:    state_d = HELD;
            HELD:    if (~|shift_d) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (state_q == FIRE) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            slow_sync_q <= '0;
            btn_sync_q  <= '0;
            sync_vld_q  <= '0;
            slow_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            shift_q     <= '0;
            state_q     <= IDLE;
            count_q     <= '0;
        end else begin
            slow_sync_q <= {slow_sync_q[0], slow_clk};
            btn_sync_q  <= {btn_sync_q[0], btn_in};
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            slow_prev_q <= slow_sync_q[1];
            armed_q     <= armed_d;
            shift_q     <= shift_d;
            state_q     <= state_d;
            count_q     <= count_d;
        end
    end

    assign step_pulse  = (state_q == FIRE);
    assign db_level    = (state_q == FIRE) || (state_q == HELD);
    assign press_count = count_q;

endmodule

// File: tb/tb_debounce_oneshot.sv
// Directed self-checking bench for debounce_oneshot with SAMPLES=4.
// The bench drives slow_clk itself, so every sample tick is known in advance.
module tb_debounce_oneshot;

    logic       clk_in;
    logic       reset;
    logic       slow_clk;
    logic       btn_in;
    logic       db_level;
    logic       step_pulse;
    logic [7:0] press_count;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;
    int exp_pulses = 0;

    debounce_oneshot #(.SAMPLES(4)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .slow_clk    (slow_clk),
        .btn_in      (btn_in),
        .db_level    (db_level),
        .step_pulse  (step_pulse),
        .press_count (press_count)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Every high cycle of step_pulse counts, so a stretched pulse shows up as extra pulses.
    always @(negedge clk_in) begin
        if (step_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full slow_clk period ending high; its rising edge produces one sample tick.
    task automatic period(input logic b, input int half);
        btn_in   = b;
        slow_clk = 1'b0;
        repeat (half) step();
        slow_clk = 1'b1;
        repeat (half) step();
    endtask

    task automatic ticks(input logic b, input int n);
        for (int i = 0; i < n; i++) period(b, 20);
    endtask

    initial begin
        reset    = 1'b1;
        slow_clk = 1'b1;
        btn_in   = 1'b1;
        repeat (5) step();
        chk("rst_db_level", db_level, 0);
        chk("rst_step_pulse", step_pulse, 0);
        chk("rst_press_count", press_count, 0);

        // Release with the strobe already high: that level must not count as a tick.
        reset = 1'b0;
        repeat (10) step();
        ticks(1'b1, 3);
        chk("no_tick_at_release_pulses", pulse_cnt, 0);
        chk("no_tick_at_release_db", db_level, 0);

        // Fourth sample tick, checked cycle by cycle.
        btn_in   = 1'b1;
        slow_clk = 1'b0;
        repeat (20) step();
        slow_clk = 1'b1;
        step();
        step();
        chk("latency_tick_cycle", step_pulse, 0);
        step();
        chk("latency_pulse_cycle", step_pulse, 1);
        chk("latency_db_level", db_level, 1);
        step();
        chk("latency_pulse_end", step_pulse, 0);
        chk("clean_count_1", press_count, 1);
        repeat (16) step();
        exp_pulses = 1;

        ticks(1'b1, 6);
        chk("held_single_pulse", pulse_cnt, exp_pulses);
        chk("held_db_level", db_level, 1);
        chk("held_count", press_count, 1);

        // Incomplete release is interrupted by a 1 sample.
        ticks(1'b0, 3);
        chk("partial_release_db", db_level, 1);
        ticks(1'b1, 1);
        chk("partial_release_db2", db_level, 1);
        chk("partial_release_pulses", pulse_cnt, exp_pulses);
        ticks(1'b0, 4);
        chk("full_release_db", db_level, 0);
        ticks(1'b1, 4);
        exp_pulses++;
        chk("repress_pulses", pulse_cnt, exp_pulses);
        chk("repress_count", press_count, 2);
        chk("repress_db", db_level, 1);

        // Bounce: 1,0,1,0 then steady 1s; only the fourth consecutive 1 fires.
        ticks(1'b0, 4);
        chk("bounce_pre_db", db_level, 0);
        period(1'b1, 20);
        period(1'b0, 20);
        period(1'b1, 20);
        period(1'b0, 20);
        ticks(1'b1, 3);
        chk("bounce_no_pulse", pulse_cnt, exp_pulses);
        chk("bounce_no_db", db_level, 0);
        ticks(1'b1, 1);
        exp_pulses++;
        chk("bounce_pulse", pulse_cnt, exp_pulses);
        chk("bounce_count", press_count, 3);

        ticks(1'b0, 4);
        ticks(1'b1, 4);
        ticks(1'b0, 4);
        ticks(1'b1, 4);
        exp_pulses += 2;
        chk("pre_reset_count", press_count, 5);
        chk("pre_reset_db", db_level, 1);

        // Asynchronous reset in HELD with the button still pressed.
        reset = 1'b1;
        #1;
        chk("midreset_db", db_level, 0);
        chk("midreset_step", step_pulse, 0);
        chk("midreset_count", press_count, 0);
        repeat (3) step();
        reset = 1'b0;
        chk("midreset_no_pulse", pulse_cnt, exp_pulses);
        ticks(1'b1, 3);
        chk("after_reset_3_ticks", pulse_cnt, exp_pulses);
        chk("after_reset_3_db", db_level, 0);
        ticks(1'b1, 1);
        exp_pulses++;
        chk("after_reset_pulse", pulse_cnt, exp_pulses);
        chk("after_reset_count", press_count, 1);

        // 255 more presses take the counter from 1 through 255 to 0.
        for (int p = 0; p < 255; p++) begin
            for (int k = 0; k < 4; k++) period(1'b0, 8);
            for (int k = 0; k < 4; k++) period(1'b1, 8);
        end
        exp_pulses += 255;
        chk("wrap_count", press_count, 0);
        chk("wrap_pulses", pulse_cnt, exp_pulses);
        chk("wrap_db", db_level, 1);

        // Strobe frozen high: button activity must not reach the state.
        slow_clk = 1'b1;
        for (int i = 0; i < 30; i++) begin
            btn_in = ~btn_in;
            repeat (7) step();
        end
        btn_in = 1'b0;
        repeat (50) step();
        chk("stall_db", db_level, 1);
        chk("stall_count", press_count, 0);
        chk("stall_pulses", pulse_cnt, exp_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
